muldiv_seq: RTL



---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_negate.sv | 12 +
 rtl/muldiv_seq.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV64M multi-cycle multiply/divide sequencer.
package muldiv_pkg;

  localparam int         MULDIV_XLEN   = 64;
  localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_negate.sv
// Combinational conditional two's-complement negation.
module muldiv_negate #(
  parameter int XLEN = 64
) (
  input  logic            neg_i,
  input  logic [XLEN-1:0] in_i,
  output logic [XLEN-1:0] out_o
);

  assign out_o = neg_i ? -in_i : in_i;

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV64M multiply/divide sequencer (shift-add multiplier, restoring divider).
// Optional MULDIV_EARLY_OUT_EN: trivial operations go straight from accept to DONE.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = MULDIV_XLEN
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CNT_W = $clog2(XLEN) + 1;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  muldiv_state_e     state_q, state_d;
  muldiv_op_e        op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic              neg_q, neg_d;
  logic              special_q, special_d;
  logic [XLEN-1:0]   special_res_q, special_res_d;
  logic [XLEN-1:0]   result_q, result_d;

  muldiv_op_e      op_in;
  logic            accept, s1, s2, neg_in, is_div_in;
  logic            div_zero, div_ovf, mul_zero, special_in;
  logic [XLEN-1:0] abs1, abs2, special_res_in;
  logic [XLEN:0]   mul_sum, rem_sh, div_diff;
  logic [XLEN-1:0] hi, lo, fix_raw, fix_neg, fix_res;
  logic            mulh_borrow;

  assign op_in     = muldiv_op_e'(funct3_i);
  assign accept    = (state_q == IDLE) && valid_i && !flush_i;
  assign is_div_in = funct3_i[2];
  assign s1 = (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && op1_i[XLEN-1];
  assign s2 = (op_in inside {OP_MULH, OP_DIV, OP_REM}) && op2_i[XLEN-1];

  muldiv_negate #(.XLEN(XLEN)) u_abs1 (.neg_i(s1), .in_i(op1_i), .out_o(abs1));
  muldiv_negate #(.XLEN(XLEN)) u_abs2 (.neg_i(s2), .in_i(op2_i), .out_o(abs2));

  // ISA-fixed results; these also decide which ops may skip the iterations.
  always_comb begin
    div_zero = is_div_in && (op2_i == '0);
    div_ovf  = (op_in inside {OP_DIV, OP_REM}) &&
               (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (op2_i == '1);
    mul_zero = !is_div_in && ((op1_i == '0) || (op2_i == '0));
    special_in     = div_zero || div_ovf || mul_zero;
    special_res_in = '0;
    if (div_zero)     special_res_in = funct3_i[1] ? op1_i : '1;
    else if (div_ovf) special_res_in = funct3_i[1] ? '0 : op1_i;
    unique case (op_in)
      OP_MULH, OP_DIV: neg_in = s1 ^ s2;
      OP_MULHSU, OP_REM: neg_in = s1;
      default: neg_in = 1'b0;
    endcase
  end

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff = rem_sh - {1'b0, opb_q};

  assign hi = acc_q[2*XLEN-1:XLEN];
  assign lo = acc_q[XLEN-1:0];
  assign fix_raw = (op_q inside {OP_MUL, OP_DIV, OP_DIVU}) ? lo : hi;
  // Negating a 2*XLEN product: the high half only takes the +1 when the low half is zero.
  assign mulh_borrow = neg_q && (op_q inside {OP_MULH, OP_MULHSU}) && (lo != '0);

  muldiv_negate #(.XLEN(XLEN)) u_fix (
    .neg_i(neg_q && !mulh_borrow), .in_i(fix_raw), .out_o(fix_neg));

  assign fix_res = mulh_borrow ? ~hi : fix_neg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      op_q          <= OP_MUL;
      cnt_q         <= '0;
      acc_q         <= '0;
      opb_q         <= '0;
      neg_q         <= 1'b0;
      special_q     <= 1'b0;
      special_res_q <= '0;
      result_q      <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      opb_q         <= opb_d;
      neg_q         <= neg_d;
      special_q     <= special_d;
      special_res_q <= special_res_d;
      result_q      <= result_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = (EARLY_OUT && special_in) ? DONE : CALC;
      CALC: if (cnt_q == '0) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  // Both operations share one accumulator: {hi, lo} = {product} or {remainder, quotient}.
  always_comb begin
    op_d          = op_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    opb_d         = opb_q;
    neg_d         = neg_q;
    special_d     = special_q;
    special_res_d = special_res_q;
    result_d      = result_q;
    if (accept) begin
      op_d          = op_in;
      cnt_d         = CNT_W'(XLEN - 1);
      acc_d         = {{XLEN{1'b0}}, abs1};
      opb_d         = abs2;
      neg_d         = neg_in;
      special_d     = special_in;
      special_res_d = special_res_in;
      if (EARLY_OUT && special_in) result_d = special_res_in;
    end else if (state_q == CALC) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (!op_q[2])           acc_d = {mul_sum, acc_q[XLEN-1:1]};
      else if (!div_diff[XLEN]) acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else                      acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else if (state_q == FIX) begin
      result_d = special_q ? special_res_q : fix_res;
    end
  end

  always_comb begin
    ready_o  = (state_q == IDLE);
    stall_o  = accept || (((state_q == CALC) || (state_q == FIX)) && !flush_i);
    done_o   = (state_q == DONE) && !flush_i;
    result_o = done_o ? result_q : '0;
  end

endmodule
